// File: rtl/fir_pkg.sv
// Shared constants, default coefficients, FSM state type and width helpers
// for the time-division FIR scheduler.
package fir_pkg;

  localparam int unsigned COEF_W = 16;

  localparam logic signed [COEF_W-1:0] DEFAULT_COEF [8] = '{
    16'sd661, 16'sd2126, 16'sd5452, 16'sd8144,
    16'sd8144, 16'sd5452, 16'sd2126, 16'sd661
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    OUT  = 2'd3
  } fir_state_e;

  // Width of one product and of the saturated result.
  function automatic int unsigned sat_w(input int unsigned width);
    return width + COEF_W;
  endfunction

  // Reset value of tap i; only the 8-tap set is defined, other sizes zero-fill.
  function automatic logic signed [COEF_W-1:0] default_coef(input int unsigned n,
                                                            input int unsigned i);
    if (n == 32'd8 && i < 32'd8) return DEFAULT_COEF[3'(i)];
    return '0;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: shadow written at any time, copied to the
// active bank only when the scheduler allows it; combinational tap read.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     we,
  input  logic [$clog2(N)-1:0]     waddr,
  input  logic signed [COEF_W-1:0] wdata,
  input  logic                     commit,
  input  logic                     apply,
  output logic                     busy,
  input  logic [$clog2(N)-1:0]     raddr,
  output logic signed [COEF_W-1:0] tap_coef_c
);

  localparam int unsigned KW = $clog2(N);

  logic signed [COEF_W-1:0] shadow [N];
  logic signed [COEF_W-1:0] active [N];

  // A write coinciding with the copy is forwarded so it lands before the copy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        shadow[i] <= default_coef(N, i);
        active[i] <= default_coef(N, i);
      end
      busy <= 1'b0;
    end else begin
      if (we) shadow[waddr] <= wdata;
      if (apply) begin
        for (int unsigned i = 0; i < N; i++)
          active[i] <= (we && waddr == KW'(i)) ? wdata : shadow[i];
      end
      if (apply)       busy <= 1'b0;
      else if (commit) busy <= 1'b1;
    end
  end

  assign tap_coef_c = active[raddr];

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Shares one signed MAC across CH sample streams: round-robin grant, per-channel
// delay lines, N-cycle tap sweep and a saturated, back-pressured result port.
module fir_tdm_scheduler
  import fir_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned WIDTH = 14,
  parameter int unsigned CH    = 2
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic [CH-1:0]                          s_valid,
  input  logic [CH*WIDTH-1:0]                    s_data,
  output logic [CH-1:0]                          s_ready,
  input  logic                                   coef_we,
  input  logic [$clog2(N)-1:0]                   coef_addr,
  input  logic signed [COEF_W-1:0]               coef_wdata,
  input  logic                                   coef_commit,
  output logic                                   coef_busy,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] m_ch,
  output logic signed [WIDTH+COEF_W-1:0]         m_data
);

  localparam int unsigned KW = $clog2(N);
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned PW = sat_w(WIDTH);
  localparam int unsigned AW = PW + KW;

  fir_state_e state, state_n;
  logic [CW-1:0]           g, g_n, g_req, rr_ptr, idx;
  logic                    found, apply;
  logic [KW-1:0]           k;
  logic signed [AW-1:0]    acc, acc_n;
  logic signed [PW-1:0]    prod, sat;
  logic signed [COEF_W-1:0] coef;
  logic signed [WIDTH-1:0] s_word [CH];
  logic signed [WIDTH-1:0] dline  [CH][N];

  fir_coef_bank #(.N(N)) u_coef_bank (
    .clk        (clk),
    .n_rst      (n_rst),
    .we         (coef_we),
    .waddr      (coef_addr),
    .wdata      (coef_wdata),
    .commit     (coef_commit),
    .apply      (apply),
    .busy       (coef_busy),
    .raddr      (k),
    .tap_coef_c (coef)
  );

  always_comb begin
    for (int unsigned i = 0; i < CH; i++) s_word[i] = s_data[i*WIDTH +: WIDTH];
  end

  // First requesting channel at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    g_req = rr_ptr;
    idx   = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      idx = CW'((32'(rr_ptr) + i) % CH);
      if (!found && s_valid[idx]) begin
        found = 1'b1;
        g_req = idx;
      end
    end
  end

  always_comb begin
    prod  = PW'(dline[g][k]) * PW'(coef);
    acc_n = acc + AW'(prod);
    if (&acc_n[AW-1:PW-1] || ~|acc_n[AW-1:PW-1]) sat = acc_n[PW-1:0];
    else if (acc_n[AW-1])                        sat = {1'b1, {(PW-1){1'b0}}};
    else                                         sat = {1'b0, {(PW-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  // Pending commits take priority over a new grant while idle.
  always_comb begin
    state_n = state;
    g_n     = g;
    apply   = 1'b0;
    unique case (state)
      IDLE: begin
        if (coef_busy) apply = 1'b1;
        else if (found) begin
          g_n     = g_req;
          state_n = LOAD;
        end
      end
      LOAD:    state_n = MAC;
      MAC:     if (k == KW'(N-1)) state_n = OUT;
      OUT:     if (m_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      g       <= '0;
      rr_ptr  <= '0;
      k       <= '0;
      acc     <= '0;
      s_ready <= '0;
      m_valid <= 1'b0;
      m_ch    <= '0;
      m_data  <= '0;
      for (int unsigned c = 0; c < CH; c++)
        for (int unsigned t = 0; t < N; t++) dline[c][t] <= '0;
    end else begin
      g       <= g_n;
      s_ready <= (state_n == LOAD) ? (CH'(1) << g_n) : '0;
      unique case (state)
        LOAD: begin
          for (int unsigned t = N-1; t > 0; t--) dline[g][t] <= dline[g][t-1];
          dline[g][0] <= s_word[g];
          acc    <= '0;
          k      <= '0;
          rr_ptr <= CW'((32'(g) + 32'd1) % CH);
        end
        MAC: begin
          acc <= acc_n;
          k   <= k + KW'(1);
          if (k == KW'(N-1)) begin
            m_data  <= sat;
            m_ch    <= g;
            m_valid <= 1'b1;
          end
        end
        OUT:     if (m_ready) m_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Directed bench for fir_tdm_scheduler: impulse, round-robin, saturation,
// backpressure, commit during MAC and reset mid-computation.
module tb_fir_tdm_scheduler;

  localparam int unsigned N     = 8;
  localparam int unsigned WIDTH = 14;
  localparam int unsigned CH    = 2;
  localparam int unsigned KW    = 3;
  localparam int unsigned PW    = 30;

  logic                    clk = 1'b0;
  logic                    n_rst = 1'b0;
  logic [CH-1:0]           s_valid = '0;
  logic [CH*WIDTH-1:0]     s_data = '0;
  logic [CH-1:0]           s_ready;
  logic                    coef_we = 1'b0;
  logic [KW-1:0]           coef_addr = '0;
  logic signed [15:0]      coef_wdata = '0;
  logic                    coef_commit = 1'b0;
  logic                    coef_busy;
  logic                    m_valid;
  logic                    m_ready = 1'b1;
  logic [0:0]              m_ch;
  logic signed [PW-1:0]    m_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  fir_tdm_scheduler #(.N(N), .WIDTH(WIDTH), .CH(CH)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
    .coef_commit (coef_commit),
    .coef_busy   (coef_busy),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_ch        (m_ch),
    .m_data      (m_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    s_valid = '0;
    coef_we = 1'b0;
    coef_commit = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  // Present one sample until accepted, then withdraw it right after the LOAD edge.
  task automatic feed(input int ch, input int val);
    int n = 0;
    s_valid = '0;
    s_valid[ch] = 1'b1;
    s_data[ch*WIDTH +: WIDTH] = WIDTH'(val);
    while (!s_ready[ch] && n < 40) begin
      tick();
      n++;
    end
    check("accept", longint'(s_ready[ch]), 1);
    tick();
    s_valid = '0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!m_valid && n < 40) begin
      tick();
      n++;
    end
    check("out_wait", longint'(m_valid), 1);
  endtask

  task automatic collect(output longint d, output int c);
    wait_out();
    d = m_data;
    c = int'(m_ch);
    tick();
  endtask

  task automatic send(input int ch, input int val, output longint d, output int c);
    feed(ch, val);
    collect(d, c);
  endtask

  initial begin
    longint d;
    int     c;
    longint exp_imp [8] = '{661, 2126, 5452, 8144, 8144, 5452, 2126, 661};
    longint rr_d [4];
    int     rr_c [4];
    int     rr_t [4];
    longint rr_exp_d [4] = '{1983, 661, 8361, 2787};
    int     rr_exp_c [4] = '{0, 1, 0, 1};
    int     got_n;
    int     bad;
    longint d0;

    // Reset state
    do_reset();
    check("rst_s_ready", longint'(s_ready), 0);
    check("rst_m_valid", longint'(m_valid), 0);
    check("rst_m_ch", longint'(m_ch), 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", longint'(coef_busy), 0);

    // Default impulse response on ch0
    for (int i = 0; i < 8; i++) begin
      send(0, (i == 0) ? 1 : 0, d, c);
      check($sformatf("imp_data%0d", i), d, exp_imp[i]);
      check($sformatf("imp_ch%0d", i), c, 0);
    end

    // Round-robin with both channels continuously valid
    do_reset();
    s_data[0*WIDTH +: WIDTH] = WIDTH'(3);
    s_data[1*WIDTH +: WIDTH] = WIDTH'(1);
    s_valid = 2'b11;
    got_n = 0;
    for (int i = 0; i < 80 && got_n < 4; i++) begin
      tick();
      if (m_valid) begin
        rr_d[got_n] = m_data;
        rr_c[got_n] = int'(m_ch);
        rr_t[got_n] = cyc;
        got_n++;
      end
    end
    s_valid = '0;
    check("rr_count", got_n, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_ch%0d", i), rr_c[i], rr_exp_c[i]);
      check($sformatf("rr_data%0d", i), rr_d[i], rr_exp_d[i]);
      if (i > 0) check($sformatf("rr_gap%0d", i), rr_t[i] - rr_t[i-1], 11);
    end
    tick();

    // Saturation with all taps at 32767
    do_reset();
    for (int i = 0; i < 8; i++) begin
      coef_we = 1'b1;
      coef_addr = KW'(i);
      coef_wdata = 16'sh7fff;
      tick();
    end
    coef_we = 1'b0;
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    check("busy_rise", longint'(coef_busy), 1);
    tick();
    check("busy_fall", longint'(coef_busy), 0);
    for (int i = 0; i < 8; i++) begin
      send(0, 8191, d, c);
      if (i == 1) check("sat_pre", d, 536788994);
    end
    check("sat_max", d, 536870911);
    for (int i = 0; i < 8; i++) send(0, -8192, d, c);
    check("sat_min", d, -536870912);

    // Backpressure while ch1 waits
    do_reset();
    m_ready = 1'b0;
    feed(0, 5);
    s_data[1*WIDTH +: WIDTH] = WIDTH'(2);
    s_valid = 2'b10;
    wait_out();
    d0 = m_data;
    check("bp_data", d0, 3305);
    check("bp_ch", longint'(m_ch), 0);
    bad = 0;
    repeat (20) begin
      tick();
      if (!m_valid || m_data != d0 || s_ready != 2'b00) bad++;
    end
    check("bp_hold", bad, 0);
    m_ready = 1'b1;
    tick();
    check("bp_release", longint'(m_valid), 0);
    tick();
    check("bp_grant", longint'(s_ready), 2);
    tick();
    s_valid = '0;
    collect(d, c);
    check("bp_next_ch", c, 1);
    check("bp_next_data", d, 1322);

    // Coefficient write and commit in the same cycle, mid-MAC
    do_reset();
    feed(0, 1);
    coef_we = 1'b1;
    coef_addr = '0;
    coef_wdata = -16'sd1000;
    coef_commit = 1'b1;
    tick();
    coef_we = 1'b0;
    coef_commit = 1'b0;
    check("cm_busy", longint'(coef_busy), 1);
    collect(d, c);
    check("cm_old_coef", d, 661);
    check("cm_pending", longint'(coef_busy), 1);
    tick();
    check("cm_clear", longint'(coef_busy), 0);
    send(0, 2, d, c);
    check("cm_new_coef", d, 126);

    // Reset in the middle of a MAC sweep
    feed(0, 100);
    tick();
    tick();
    n_rst = 1'b0;
    #1;
    check("mr_s_ready", longint'(s_ready), 0);
    check("mr_m_valid", longint'(m_valid), 0);
    check("mr_m_ch", longint'(m_ch), 0);
    check("mr_m_data", m_data, 0);
    check("mr_busy", longint'(coef_busy), 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    bad = 0;
    repeat (15) begin
      tick();
      if (m_valid) bad++;
    end
    check("mr_no_out", bad, 0);
    send(0, 1, d, c);
    check("mr_imp0", d, 661);
    send(0, 0, d, c);
    check("mr_imp1", d, 2126);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
